// File: rtl/dot_channel_param.sv
// Streaming fixed-point dot-product channel: PASSES beats of LANES elements are
// multiplied against stored weight rows, accumulated, then rescaled to one result.
module dot_channel_param #(
    parameter int    DATA_LEN  = 16,
    parameter int    LANES     = 36,
    parameter int    PASSES    = 6,
    parameter int    FRAC_BITS = 8,
    parameter string FILENAME  = "",
    localparam int   AW        = (PASSES > 1) ? $clog2(PASSES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          relu_en,
    input  logic                          w_we,
    input  logic [AW-1:0]                 w_addr,
    input  logic [LANES*DATA_LEN-1:0]     w_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_LEN-1:0]     d,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_LEN-1:0]           q
);

    localparam int PW    = 2 * DATA_LEN;
    localparam int ACC_W = PW + $clog2(LANES * PASSES);
    localparam logic [AW-1:0] LAST = AW'(PASSES - 1);
    localparam logic signed [ACC_W-1:0] QMAX = {{(ACC_W-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] QMIN = {{(ACC_W-DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};

    typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

    state_t                      state, state_nx;
    logic                        armed;
    logic [AW-1:0]               pass_cnt;
    logic                        pipe_v;
    logic [LANES*DATA_LEN-1:0]   d_r;
    logic [LANES*DATA_LEN-1:0]   w_r;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     dot;
    logic signed [ACC_W-1:0]     shifted;
    logic [DATA_LEN-1:0]         q_nx;
    logic                        accept;
    logic                        last_beat;
    logic                        out_fire;

    logic [LANES*DATA_LEN-1:0]   wmem [PASSES];

    always_ff @(posedge clk) begin
        if (w_we && w_addr <= LAST)
            wmem[w_addr] <= w_data;
    end

    assign accept    = in_valid && in_ready && !clear;
    assign last_beat = (pass_cnt == LAST);
    assign out_fire  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = ACC;
        end else begin
            unique case (state)
                ACC:     if (accept && last_beat) state_nx = DRAIN;
                DRAIN:   if (!pipe_v)             state_nx = HOLD;
                HOLD:    if (out_fire)            state_nx = ACC;
                default:                          state_nx = ACC;
            endcase
        end
    end

    // Outputs: in_ready waits one edge after reset release via armed
    always_comb begin
        in_ready = armed && (state == ACC);
    end

    always_comb begin
        dot = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            logic signed [DATA_LEN-1:0] a;
            logic signed [DATA_LEN-1:0] b;
            logic signed [PW-1:0]       prod;
            a    = d_r[i*DATA_LEN +: DATA_LEN];
            b    = w_r[i*DATA_LEN +: DATA_LEN];
            prod = a * b;
            dot  = dot + ACC_W'(prod);
        end
    end

    always_comb begin
        shifted = acc >>> FRAC_BITS;
        if (shifted > QMAX)
            q_nx = {1'b0, {(DATA_LEN-1){1'b1}}};
        else if (shifted < QMIN)
            q_nx = {1'b1, {(DATA_LEN-1){1'b0}}};
        else
            q_nx = shifted[DATA_LEN-1:0];
        if (relu_en && q_nx[DATA_LEN-1])
            q_nx = '0;
    end

    // Datapath: beat register stage, accumulate one cycle later, result capture on entering HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            pass_cnt  <= '0;
            pipe_v    <= 1'b0;
            d_r       <= '0;
            w_r       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            q         <= '0;
        end else begin
            armed <= 1'b1;
            if (clear) begin
                pass_cnt  <= '0;
                pipe_v    <= 1'b0;
                acc       <= '0;
                out_valid <= 1'b0;
            end else begin
                pipe_v <= accept;
                if (accept) begin
                    d_r      <= d;
                    w_r      <= wmem[pass_cnt];
                    pass_cnt <= last_beat ? '0 : pass_cnt + AW'(1);
                end
                if (pipe_v)
                    acc <= acc + dot;
                if (state == DRAIN && !pipe_v) begin
                    q         <= q_nx;
                    out_valid <= 1'b1;
                end
                if (state == HOLD && out_fire) begin
                    out_valid <= 1'b0;
                    acc       <= '0;
                    pass_cnt  <= '0;
                end
            end
        end
    end

endmodule
